// File: rtl/traffic_pkg.sv
// Shared lamp codes, phase encoding and width helper for the intersection controllers.
package traffic_pkg;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_GREEN  = 2'b10;

  typedef enum logic [1:0] {
    PH_GREEN   = 2'd0,
    PH_YELLOW  = 2'd1,
    PH_ALL_RED = 2'd2
  } phase_e;

  // Ceiling log2, never below 1 so a two-entry index still gets one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_rr_next_sel.sv
// Rotate-priority search: first pending approach after active_idx (wrapping), plus a
// flag telling whether any approach other than the active one is waiting.
module rr_next_sel
  import traffic_pkg::*;
#(
  parameter  int NUM_APPROACH = 4,
  localparam int IDX_W        = clog2(NUM_APPROACH)
) (
  input  logic [NUM_APPROACH-1:0] pending,
  input  logic [IDX_W-1:0]        active_idx,
  output logic [IDX_W-1:0]        sel,
  output logic                    any_other
);

  localparam int N = NUM_APPROACH;

  logic [2*N-1:0] w_dbl;
  logic [IDX_W:0] w_shift;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_mask;
  logic           w_found;
  logic [IDX_W:0] w_sum;

  // Rotating the doubled vector puts approach active_idx+1 at bit 0, so the search is a plain LSB-first scan.
  assign w_dbl   = {pending, pending};
  assign w_shift = {1'b0, active_idx} + (IDX_W+1)'(1);
  assign w_rot   = N'(w_dbl >> w_shift);

  always_comb begin
    w_found = 1'b0;
    w_sum   = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = w_shift + (IDX_W+1)'(k);
      end
    end
    if (w_sum >= (IDX_W+1)'(N)) sel = IDX_W'(w_sum - (IDX_W+1)'(N));
    else                        sel = IDX_W'(w_sum);
  end

  assign w_mask    = ~(N'(1) << active_idx);
  assign any_other = |(pending & w_mask);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-approach phase controller: latched calls served round-robin with min/max green,
// gap extension and yellow/all-red clearance. Define PREEMPT_EN for the preemption ports.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter  int NUM_APPROACH = 4,
  parameter  int T_MIN_GREEN  = 8,
  parameter  int T_MAX_GREEN  = 20,
  parameter  int T_YELLOW     = 3,
  parameter  int T_ALL_RED    = 2,
  localparam int IDX_W        = clog2(NUM_APPROACH),
  localparam int CNT_W        = clog2(T_MAX_GREEN + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_APPROACH-1:0]   req,
`ifdef PREEMPT_EN
  input  logic                      preempt,
  input  logic [IDX_W-1:0]          preempt_idx,
`endif
  output logic [2*NUM_APPROACH-1:0] lights,
  output logic [IDX_W-1:0]          active_idx,
  output logic [1:0]                phase,
  output logic [NUM_APPROACH-1:0]   pending
);

  localparam int N = NUM_APPROACH;

  phase_e           r_phase;
  phase_e           w_phaseNext;
  logic [IDX_W-1:0] r_active;
  logic [IDX_W-1:0] w_activeNext;
  logic [CNT_W-1:0] r_timer;
  logic [N-1:0]     r_pending;
  logic [N-1:0]     w_pendingSet;
  logic [N-1:0]     w_pendingClr;
  logic [N-1:0]     w_activeOneHot;
  logic [IDX_W-1:0] w_sel;
  logic             w_anyOther;
  logic             w_normalLeave;
  logic             w_leaveGreen;
  logic [IDX_W-1:0] w_target;
  logic             w_enterGreen;

  rr_next_sel #(
    .NUM_APPROACH(N)
  ) u_rr_next_sel (
    .pending   (r_pending),
    .active_idx(r_active),
    .sel       (w_sel),
    .any_other (w_anyOther)
  );

  // Gap-out needs the minimum served; max-out only matters while the active approach still demands.
  assign w_normalLeave = (r_timer >= CNT_W'(T_MIN_GREEN - 1)) && w_anyOther &&
                         (!req[r_active] || (r_timer >= CNT_W'(T_MAX_GREEN - 1)));

`ifdef PREEMPT_EN
  logic             r_preValid;
  logic [IDX_W-1:0] r_preIdx;

  assign w_leaveGreen = preempt ? (r_active != preempt_idx) : w_normalLeave;
  assign w_target     = preempt ? preempt_idx : (r_preValid ? r_preIdx : w_sel);

  // Remember the preemption target so clearance still ends on it if the request drops early.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_preValid <= 1'b0;
      r_preIdx   <= '0;
    end else if (w_enterGreen) begin
      r_preValid <= 1'b0;
    end else if (preempt && !(r_phase == PH_GREEN && r_active == preempt_idx)) begin
      r_preValid <= 1'b1;
      r_preIdx   <= preempt_idx;
    end
  end
`else
  assign w_leaveGreen = w_normalLeave;
  assign w_target     = w_sel;
`endif

  always_comb begin
    w_phaseNext  = r_phase;
    w_activeNext = r_active;
    w_enterGreen = 1'b0;
    unique case (r_phase)
      PH_GREEN:   if (w_leaveGreen) w_phaseNext = PH_YELLOW;
      PH_YELLOW:  if (r_timer == CNT_W'(T_YELLOW - 1)) w_phaseNext = PH_ALL_RED;
      PH_ALL_RED: begin
        if (r_timer == CNT_W'(T_ALL_RED - 1)) begin
          w_phaseNext  = PH_GREEN;
          w_activeNext = w_target;
          w_enterGreen = 1'b1;
        end
      end
      default:    w_phaseNext = PH_GREEN;
    endcase
  end

  assign w_activeOneHot = N'(1) << r_active;
  assign w_pendingSet   = req & ~((r_phase == PH_GREEN) ? w_activeOneHot : '0);
  assign w_pendingClr   = w_enterGreen ? (N'(1) << w_activeNext) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase   <= PH_GREEN;
      r_active  <= '0;
      r_timer   <= '0;
      r_pending <= '0;
    end else begin
      r_phase   <= w_phaseNext;
      r_active  <= w_activeNext;
      r_pending <= (r_pending | w_pendingSet) & ~w_pendingClr;
      if (w_phaseNext != r_phase)
        r_timer <= '0;
      else if (r_timer != CNT_W'(T_MAX_GREEN))
        r_timer <= r_timer + CNT_W'(1);
    end
  end

  always_comb begin
    lights = '0;
    for (int i = 0; i < N; i++) begin
      if (IDX_W'(i) == r_active) begin
        unique case (r_phase)
          PH_GREEN:  lights[2*i +: 2] = LAMP_GREEN;
          PH_YELLOW: lights[2*i +: 2] = LAMP_YELLOW;
          default:   lights[2*i +: 2] = LAMP_RED;
        endcase
      end
    end
  end

  assign active_idx = r_active;
  assign phase      = r_phase;
  assign pending    = r_pending;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed scenarios plus randomized calls
// compared against a cycle-counting reference model. PREEMPT_EN adds a preemption scenario.
module tb_traffic_phase_ctrl;

  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int TMIN = 8;
  localparam int TMAX = 20;
  localparam int TY   = 3;
  localparam int TAR  = 2;
  localparam int W    = 2 + IW + N + 2*N;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [2*N-1:0] lights;
  logic [IW-1:0]  active_idx;
  logic [1:0]     phase;
  logic [N-1:0]   pending;
`ifdef PREEMPT_EN
  logic           preempt = 1'b0;
  logic [IW-1:0]  preempt_idx = '0;
`endif

  int checks = 0;
  int errors = 0;

  int           mPhase;
  int           mActive;
  int           mElapsed;
  logic [N-1:0] mPend;

  traffic_phase_ctrl #(
    .NUM_APPROACH(N),
    .T_MIN_GREEN (TMIN),
    .T_MAX_GREEN (TMAX),
    .T_YELLOW    (TY),
    .T_ALL_RED   (TAR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
`ifdef PREEMPT_EN
    .preempt    (preempt),
    .preempt_idx(preempt_idx),
`endif
    .lights     (lights),
    .active_idx (active_idx),
    .phase      (phase),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  // Reference model: phases measured by elapsed cycles, next approach by distance around the ring.
  task automatic modelStep(input logic [N-1:0] r, input logic rs);
    int t;
    int nxt;
    bit other;
    logic [N-1:0] np;
    if (rs) begin
      mPhase = 0; mActive = 0; mElapsed = 0; mPend = '0;
      return;
    end
    t = (mElapsed > TMAX) ? TMAX : mElapsed;
    other = 1'b0;
    for (int j = 0; j < N; j++) if (j != mActive && mPend[j]) other = 1'b1;
    np = mPend;
    for (int i = 0; i < N; i++) if (r[i] && !(i == mActive && mPhase == 0)) np[i] = 1'b1;
    case (mPhase)
      0: if (t >= TMIN-1 && other && (!r[mActive] || t >= TMAX-1)) begin
           mPhase = 1; mElapsed = 0;
         end else mElapsed++;
      1: if (mElapsed == TY-1) begin mPhase = 2; mElapsed = 0; end
         else mElapsed++;
      default: if (mElapsed == TAR-1) begin
           nxt = 0;
           for (int d = N; d >= 1; d--) if (mPend[(mActive + d) % N]) nxt = (mActive + d) % N;
           mActive = nxt; mPhase = 0; mElapsed = 0; np[nxt] = 1'b0;
         end else mElapsed++;
    endcase
    mPend = np;
  endtask

  function automatic logic [W-1:0] expWord();
    logic [2*N-1:0] l;
    l = '0;
    for (int i = 0; i < N; i++)
      if (i == mActive) l[2*i +: 2] = (mPhase == 0) ? 2'b10 : (mPhase == 1) ? 2'b01 : 2'b00;
    return {2'(mPhase), IW'(mActive), mPend, l};
  endfunction

  // Drive one cycle of inputs, advance the model, and land #1 after the active edge.
  task automatic applyStimulus(input logic [N-1:0] r, input logic rs);
    req = r;
    rst = rs;
    modelStep(r, rs);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(N'($urandom), 1'b1);
    applyStimulus(N'($urandom), 1'b1);
    checks++;
    if ({phase, active_idx, pending, lights} !== {2'd0, 2'd0, 4'b0000, 8'b0000_0010}) begin
      errors++;
      $display("[TB] FAIL reset_state got=%h exp=%h", {phase, active_idx, pending, lights},
               {2'd0, 2'd0, 4'b0000, 8'b0000_0010});
    end
  endtask

  task automatic test_rest();
    applyStimulus('0, 1'b1);
    for (int c = 0; c < 100; c++) begin
      checks++;
      if ({phase, lights} !== {2'd0, 8'b0000_0010}) begin
        errors++;
        $display("[TB] FAIL rest c=%0d phase/lights got=%h exp=%h", c, {phase, lights}, {2'd0, 8'h02});
      end
      applyStimulus('0, 1'b0);
    end
  endtask

  task automatic test_single_call();
    logic [IW+1:0] e;
    applyStimulus('0, 1'b1);
    for (int c = 0; c <= 14; c++) begin
      e = (c <= 7) ? {2'd0, 2'd0} : (c <= 10) ? {2'd1, 2'd0} : (c <= 12) ? {2'd2, 2'd0} : {2'd0, 2'd2};
      checks++;
      if ({phase, active_idx} !== e) begin
        errors++;
        $display("[TB] FAIL single_call c=%0d phase/idx got=%h exp=%h", c, {phase, active_idx}, e);
      end
      if (c == 1 || c == 13) begin
        checks++;
        if (pending !== ((c == 1) ? 4'b0100 : 4'b0000)) begin
          errors++;
          $display("[TB] FAIL single_call_pending c=%0d got=%b exp=%b", c, pending,
                   (c == 1) ? 4'b0100 : 4'b0000);
        end
      end
      applyStimulus((c == 0) ? 4'b0100 : 4'b0000, 1'b0);
    end
  endtask

  task automatic test_max_out();
    logic [IW+1:0] e;
    applyStimulus('0, 1'b1);
    for (int c = 0; c <= 26; c++) begin
      e = (c <= 19) ? {2'd0, 2'd0} : (c <= 22) ? {2'd1, 2'd0} : (c <= 24) ? {2'd2, 2'd0} : {2'd0, 2'd1};
      checks++;
      if ({phase, active_idx} !== e) begin
        errors++;
        $display("[TB] FAIL max_out c=%0d phase/idx got=%h exp=%h", c, {phase, active_idx}, e);
      end
      applyStimulus((c == 0) ? 4'b0011 : 4'b0001, 1'b0);
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] r;
    applyStimulus('0, 1'b1);
    for (int c = 0; c <= 39; c++) begin
      checks++;
      if ({phase, active_idx, pending, lights} !== expWord()) begin
        errors++;
        $display("[TB] FAIL wrap_model c=%0d got=%h exp=%h", c, {phase, active_idx, pending, lights}, expWord());
      end
      if (c == 13 || c == 26 || c == 39) begin
        checks++;
        if ({phase, active_idx} !== {2'd0, (c == 13) ? 2'd3 : (c == 26) ? 2'd1 : 2'd2}) begin
          errors++;
          $display("[TB] FAIL wrap_order c=%0d phase/idx got=%h exp=%h", c, {phase, active_idx},
                   {2'd0, (c == 13) ? 2'd3 : (c == 26) ? 2'd1 : 2'd2});
        end
      end
      r = (c == 0) ? 4'b1000 : (c == 14) ? 4'b0010 : (c == 22) ? 4'b1000 : (c == 27) ? 4'b0100 : 4'b0000;
      applyStimulus(r, 1'b0);
    end
  endtask

  task automatic test_reset_mid_yellow();
    applyStimulus('0, 1'b1);
    for (int c = 0; c < 22; c++)
      applyStimulus((c == 0) ? 4'b0010 : (c == 14) ? 4'b0100 : 4'b0000, 1'b0);
    checks++;
    if ({phase, active_idx} !== {2'd1, 2'd1}) begin
      errors++;
      $display("[TB] FAIL pre_reset_yellow got=%h exp=%h", {phase, active_idx}, {2'd1, 2'd1});
    end
    applyStimulus(4'b0110, 1'b1);
    checks++;
    if ({phase, active_idx, pending, lights} !== {2'd0, 2'd0, 4'b0000, 8'b0000_0010}) begin
      errors++;
      $display("[TB] FAIL reset_mid_yellow got=%h exp=%h", {phase, active_idx, pending, lights},
               {2'd0, 2'd0, 4'b0000, 8'b0000_0010});
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    int density;
    r = '0;
    density = 8;
    applyStimulus('0, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) density = $urandom_range(2, 24);
      if ($urandom_range(0, 3) != 0)
        for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, density - 1) == 0);
      applyStimulus(r, ($urandom_range(0, 599) == 0));
      checks++;
      if ({phase, active_idx, pending, lights} !== expWord()) begin
        errors++;
        $display("[TB] FAIL random c=%0d got=%h exp=%h", c, {phase, active_idx, pending, lights}, expWord());
      end
    end
  endtask

`ifdef PREEMPT_EN
  task automatic test_preempt();
    preempt = 1'b0;
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b0);
    applyStimulus('0, 1'b0);
    preempt     = 1'b1;
    preempt_idx = 2'd3;
    applyStimulus(4'b0010, 1'b0);
    checks++;
    if ({phase, active_idx} !== {2'd1, 2'd0}) begin
      errors++;
      $display("[TB] FAIL preempt_yellow got=%h exp=%h", {phase, active_idx}, {2'd1, 2'd0});
    end
    for (int c = 3; c < 8; c++) applyStimulus('0, 1'b0);
    for (int c = 0; c < 50; c++) begin
      checks++;
      if ({phase, active_idx, pending[1]} !== {2'd0, 2'd3, 1'b1}) begin
        errors++;
        $display("[TB] FAIL preempt_hold c=%0d got=%h exp=%h", c, {phase, active_idx, pending[1]},
                 {2'd0, 2'd3, 1'b1});
      end
      applyStimulus('0, 1'b0);
    end
    preempt = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_rest();
    test_single_call();
    test_max_out();
    test_wrap();
    test_reset_mid_yellow();
    test_random();
`ifdef PREEMPT_EN
    test_preempt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
